multiplier: RTL and testbench

MULTIPLIER -- requirements
Module: multiplier

---
 rtl/multiplier.sv | 106 ++++++++++
 tb/tb_multiplier.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/multiplier.sv
// Sequential 32x32 shift-add multiplier with signed/unsigned operands and upper/lower word select.
// Optional MULTIPLIER_EARLY_EXIT_EN stops iterating once the remaining multiplier bits are all zero.
module multiplier (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        go,
    input  logic        muls,
    input  logic        high,
    output logic [31:0] c,
    output logic        is_zero,
    output logic        is_negative,
    output logic        available,
    output logic [1:0]  mul_state
);

    localparam logic [1:0] MUL_ADD       = 2'd0;
    localparam logic [1:0] MUL_NEGATE    = 2'd1;
    localparam logic [1:0] MUL_AVAILABLE = 2'd2;
    localparam logic [1:0] MUL_DONE      = 2'd3;

    logic [1:0]  state;
    logic [63:0] multiplicand;
    logic [63:0] product;
    logic [31:0] multiplier_q;
    logic [5:0]  count;
    logic        sign;
    logic        high_q;

    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] multiplier_shifted;
    logic        last_iter;

    // Magnitudes stay 32-bit unsigned, so -(2^31) maps cleanly to 2^31.
    always_comb begin
        a_mag = (muls && a[31]) ? (~a + 32'd1) : a;
        b_mag = (muls && b[31]) ? (~b + 32'd1) : b;
        multiplier_shifted = multiplier_q >> 1;
`ifdef MULTIPLIER_EARLY_EXIT_EN
        last_iter = (count == 6'd31) || (multiplier_shifted == 32'd0);
`else
        last_iter = (count == 6'd31);
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= MUL_DONE;
            multiplicand <= 64'd0;
            product      <= 64'd0;
            multiplier_q <= 32'd0;
            count        <= 6'd0;
            sign         <= 1'b0;
            high_q       <= 1'b0;
            available    <= 1'b0;
        end else if (go) begin
            // A new request restarts from any state, dropping whatever was in flight.
            state        <= MUL_ADD;
            multiplicand <= {32'd0, a_mag};
            multiplier_q <= b_mag;
            product      <= 64'd0;
            count        <= 6'd0;
            sign         <= muls & (a[31] ^ b[31]);
            high_q       <= high;
            available    <= 1'b0;
        end else begin
            case (state)
                MUL_ADD: begin
                    if (multiplier_q[0]) begin
                        product <= product + multiplicand;
                    end
                    multiplicand <= multiplicand << 1;
                    multiplier_q <= multiplier_shifted;
                    count        <= count + 6'd1;
                    if (last_iter) begin
                        state <= MUL_NEGATE;
                    end
                end
                MUL_NEGATE: begin
                    if (sign) begin
                        product <= ~product + 64'd1;
                    end
                    state <= MUL_AVAILABLE;
                end
                MUL_AVAILABLE: begin
                    available <= 1'b1;
                    state     <= MUL_DONE;
                end
                MUL_DONE: begin
                    available <= 1'b0;
                end
                default: begin
                    state <= MUL_DONE;
                end
            endcase
        end
    end

    assign c           = high_q ? product[63:32] : product[31:0];
    assign is_zero     = (c == 32'd0);
    assign is_negative = c[31];
    assign mul_state   = state;

endmodule

// File: tb/tb_multiplier.sv
// Self-checking bench for multiplier: directed corner cases plus random operations
// checked against an arithmetic reference model and an expected-result queue.
module tb_multiplier;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        go;
    logic        muls;
    logic        high;
    logic [31:0] c;
    logic        is_zero;
    logic        is_negative;
    logic        available;
    logic [1:0]  mul_state;

    int tests_run = 0;
    int tests_failed = 0;
    logic [31:0] exp_q[$];
    int          exp_lat_q[$];
    logic [31:0] last_exp;

    multiplier dut (
        .clk        (clk),
        .reset      (reset),
        .a          (a),
        .b          (b),
        .go         (go),
        .muls       (muls),
        .high       (high),
        .c          (c),
        .is_zero    (is_zero),
        .is_negative(is_negative),
        .available  (available),
        .mul_state  (mul_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reference model: plain 64-bit arithmetic
    function automatic logic [31:0] ref_c(input logic [31:0] ra, input logic [31:0] rb,
                                          input logic rmuls, input logic rhigh);
        longint          sa;
        longint          sb;
        longint unsigned ua;
        longint unsigned ub;
        logic [63:0]     p;
        if (rmuls) begin
            sa = longint'($signed(ra));
            sb = longint'($signed(rb));
            p  = 64'(sa * sb);
        end else begin
            ua = 64'(ra);
            ub = 64'(rb);
            p  = ua * ub;
        end
        return rhigh ? p[63:32] : p[31:0];
    endfunction

    function automatic int ref_latency(input logic [31:0] rb, input logic rmuls);
        logic [31:0] mag;
        int          k;
        mag = (rmuls && rb[31]) ? (32'd0 - rb) : rb;
        k = 1;
        for (int i = 0; i < 32; i++) begin
            if (mag[i]) k = i + 1;
        end
`ifdef MULTIPLIER_EARLY_EXIT_EN
        return k + 2;
`else
        return 34;
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        tests_run++;
        assert (obs === expv) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // driver: called just after a rising edge; go is sampled at the next edge
    task automatic start_op(input logic [31:0] da, input logic [31:0] db,
                            input logic dmuls, input logic dhigh);
        a    = da;
        b    = db;
        muls = dmuls;
        high = dhigh;
        go   = 1'b1;
        exp_q.delete();
        exp_lat_q.delete();
        exp_q.push_back(ref_c(da, db, dmuls, dhigh));
        exp_lat_q.push_back(ref_latency(db, dmuls));
        @(posedge clk);
        #1;
        go = 1'b0;
    endtask

    // bounded wait for the single available pulse; operand inputs toggle meanwhile
    task automatic wait_result(input string tag);
        int          seen;
        int          first;
        int          lat;
        logic [31:0] expv;
        seen  = 0;
        first = 0;
        lat   = exp_lat_q.size() > 0 ? exp_lat_q.pop_front() : 34;
        for (int i = 1; i <= lat + 3; i++) begin
            @(posedge clk);
            #1;
            a    = $urandom;
            b    = $urandom;
            muls = 1'($urandom_range(0, 1));
            high = 1'($urandom_range(0, 1));
            if (available) begin
                seen++;
                if (seen == 1) begin
                    first = i;
                    expv = exp_q.size() > 0 ? exp_q.pop_front() : 32'hDEAD_BEEF;
                    last_exp = expv;
                    check({tag, ".c"}, c, expv);
                    check({tag, ".is_zero"}, 32'(is_zero), 32'(expv == 32'd0));
                    check({tag, ".is_negative"}, 32'(is_negative), 32'(expv[31]));
                end
            end
        end
        check({tag, ".pulses"}, 32'(seen), 32'd1);
        check({tag, ".latency"}, 32'(first), 32'(lat));
        check({tag, ".hold"}, c, last_exp);
    endtask

    task automatic run_op(input string tag, input logic [31:0] da, input logic [31:0] db,
                          input logic dmuls, input logic dhigh);
        start_op(da, db, dmuls, dhigh);
        wait_result(tag);
    endtask

    initial begin
        int pulses;
        logic [31:0] ra;
        logic [31:0] rb;
        reset    = 1'b0;
        go       = 1'b0;
        a        = 32'd0;
        b        = 32'd0;
        muls     = 1'b0;
        high     = 1'b0;
        last_exp = 32'd0;
        repeat (3) @(posedge clk);
        #1;
        check("reset.c", c, 32'd0);
        check("reset.is_zero", 32'(is_zero), 32'd1);
        check("reset.is_negative", 32'(is_negative), 32'd0);
        check("reset.available", 32'(available), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // directed corner cases
        run_op("u7x6", 32'd7, 32'd6, 1'b0, 1'b0);
        run_op("uff_hi", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1);
        run_op("uff_lo", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        run_op("sm3x5_lo", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0);
        run_op("sm3x5_hi", 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b1);
        run_op("smin_hi", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
        run_op("smin_lo", 32'h8000_0000, 32'h8000_0000, 1'b1, 1'b0);
        run_op("b1", 32'h1234_5678, 32'd1, 1'b0, 1'b0);
        run_op("b0", 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        run_op("bmsb", 32'd3, 32'h8000_0000, 1'b0, 1'b0);

        // abort: second go ten edges after the first replaces it
        start_op(32'd9, 32'd9, 1'b0, 1'b0);
        pulses = 0;
        repeat (9) begin
            @(posedge clk);
            #1;
            if (available) pulses++;
        end
        check("abort.early_pulse", 32'(pulses), 32'd0);
        run_op("abort", 32'd2, 32'd3, 1'b0, 1'b0);

        // reset mid-operation discards it; go during reset is ignored
        start_op(32'd100, 32'd100, 1'b0, 1'b0);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid.c", c, 32'd0);
        check("rst_mid.available", 32'(available), 32'd0);
        a  = 32'd5;
        b  = 32'd5;
        go = 1'b1;
        @(posedge clk);
        #1;
        go = 1'b0;
        exp_q.delete();
        @(negedge clk);
        reset = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (available) pulses++;
        end
        check("rst_mid.no_pulse", 32'(pulses), 32'd0);
        check("rst_mid.c_after", c, 32'd0);

        // random operations, some with narrow multipliers to exercise early exit
        for (int n = 0; n < 40; n++) begin
            ra = $urandom;
            rb = $urandom;
            if (n % 4 == 1) rb = rb >> $urandom_range(1, 31);
            run_op("rand", ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
